// File: rtl/raybox_pkg.sv
// Shared constants, FSM encoding and texv saturation helper for the row feeder.
// Sized copies of the constants keep comparisons width-exact.
package raybox_pkg;

  localparam int H_VIEW = 640;
  localparam int HALF   = H_VIEW / 2;
  localparam int FRAC   = 12;
  localparam int STEP_W = 18;

  // One extra quotient bit so a span of 1 can hold 2^18 exactly.
  localparam int QUO_W  = STEP_W + 1;
  localparam int SIZE_W = 11;
  localparam int TEXU_W = 6;
  localparam int TEXV_W = 6;
  localparam int HPOS_W = 10;
  localparam int SPAN_W = 12;
  localparam int ACC_W  = 20;

  localparam logic [SIZE_W-1:0] HALF_S    = SIZE_W'(HALF);
  localparam logic [HPOS_W-1:0] H_VIEW_H  = HPOS_W'(H_VIEW);
  localparam logic [4:0]        DIV_ITERS = 5'(STEP_W);
  localparam logic [3:0]        MUL_ITERS = 4'(SIZE_W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DIV   = 2'd1,
    ST_MUL   = 2'd2,
    ST_READY = 2'd3
  } feed_state_e;

  function automatic logic [TEXV_W-1:0] texv_sat(input logic [ACC_W-1:0] acc);
    if (|acc[ACC_W-1:FRAC+TEXV_W]) return '1;
    return acc[FRAC+TEXV_W-1:FRAC];
  endfunction

endpackage

// File: rtl/row_feeder_if.sv
// Tracer handshake, line timing and per-pixel output bundle of the row feeder.
interface row_feeder_if;
  import raybox_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic              in_side;
  logic [SIZE_W-1:0] in_size;
  logic [TEXU_W-1:0] in_texu;
  logic              line_start;
  logic [HPOS_W-1:0] hpos;
  logic              side;
  logic [SIZE_W-1:0] size;
  logic [TEXU_W-1:0] texu;
  logic [TEXV_W-1:0] texv;
  logic              busy;
  logic              underrun;

  modport master (
    output in_valid, in_side, in_size, in_texu, line_start, hpos,
    input  in_ready, side, size, texu, texv, busy, underrun
  );

  modport slave (
    input  in_valid, in_side, in_size, in_texu, line_start, hpos,
    output in_ready, side, size, texu, texv, busy, underrun
  );

endinterface

// File: rtl/recip_div.sv
// Restoring divider computing 2^18 / divisor in exactly 18 iteration cycles.
// The dividend's single set bit is folded into the start cycle.
module recip_div
  import raybox_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [SPAN_W-1:0] divisor_i,
  output logic              done_o,
  output logic [QUO_W-1:0]  quot_o
);

  logic [SPAN_W-1:0] rem_q, rem_d;
  logic [SPAN_W-1:0] divisor_q, divisor_d;
  logic [QUO_W-1:0]  quot_q, quot_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [SPAN_W:0]   trial;
  logic              qbit;

  // Remaining dividend bits are all zero, so each step just doubles the remainder.
  always_comb begin
    rem_d     = rem_q;
    divisor_d = divisor_q;
    quot_d    = quot_q;
    cnt_d     = cnt_q;
    trial     = {rem_q, 1'b0};
    qbit      = trial >= {1'b0, divisor_q};
    if (start_i) begin
      divisor_d = divisor_i;
      rem_d     = (divisor_i == SPAN_W'(1)) ? '0 : SPAN_W'(1);
      quot_d    = {(divisor_i == SPAN_W'(1)), STEP_W'(0)};
      cnt_d     = DIV_ITERS;
    end else if (cnt_q != 5'd0) begin
      rem_d  = qbit ? SPAN_W'(trial - {1'b0, divisor_q}) : trial[SPAN_W-1:0];
      quot_d = {quot_q[STEP_W], quot_q[STEP_W-2:0], qbit};
      cnt_d  = cnt_q - 5'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q     <= '0;
      divisor_q <= '0;
      quot_q    <= '0;
      cnt_q     <= '0;
    end else begin
      rem_q     <= rem_d;
      divisor_q <= divisor_d;
      quot_q    <= quot_d;
      cnt_q     <= cnt_d;
    end
  end

  // High during the final iteration; the quotient is complete from the next cycle.
  assign done_o = (cnt_q == 5'd1);
  assign quot_o = quot_q;

endmodule

// File: rtl/row_feeder.sv
// Double-buffers one traced wall result per line and streams side/size/texu
// plus a per-pixel texture v derived from a reciprocal step and pre-offset.
module row_feeder
  import raybox_pkg::*;
(
  input logic         clk,
  input logic         reset,
  row_feeder_if.slave bus
);

  feed_state_e       state_q;
  logic              pend_full_q, pend_full_d;
  logic              pend_side_q;
  logic [SIZE_W-1:0] pend_size_q;
  logic [TEXU_W-1:0] pend_texu_q;
  logic              side_q;
  logic [SIZE_W-1:0] size_q;
  logic [TEXU_W-1:0] texu_q;
  logic [TEXV_W-1:0] texv_q, texv_d;
  logic              busy_q;
  logic              underrun_q;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  pre_q;
  logic [SIZE_W-1:0] mplier_q;
  logic [3:0]        mcnt_q;

  logic              accept;
  logic              promote;
  logic [SIZE_W-1:0] size_next;
  logic [SPAN_W-1:0] span;
  logic [SPAN_W-1:0] start_pos, end_pos, hpos_ext;
  logic              clip, in_span, div_done;
  logic [QUO_W-1:0]  step;

  assign accept  = bus.in_valid && !pend_full_q;
  assign promote = bus.line_start && pend_full_q;

  // The divider starts on the line_start edge, so it must see the size being promoted.
  always_comb begin
    pend_full_d = pend_full_q;
    if (promote) pend_full_d = 1'b0;
    if (accept)  pend_full_d = 1'b1;
    size_next = promote ? pend_size_q : size_q;
    span      = {size_next, 1'b1};
  end

  recip_div u_div (
    .clk       (clk),
    .reset     (reset),
    .start_i   (bus.line_start),
    .divisor_i (span),
    .done_o    (div_done),
    .quot_o    (step)
  );

  always_comb begin
    clip      = size_q > HALF_S;
    start_pos = clip ? '0 : SPAN_W'(HALF_S - size_q);
    end_pos   = SPAN_W'(HALF_S) + SPAN_W'(size_q);
    hpos_ext  = SPAN_W'(bus.hpos);
    in_span   = (hpos_ext >= start_pos) && (hpos_ext <= end_pos) && (bus.hpos < H_VIEW_H);
    acc_d     = acc_q;
    if (hpos_ext == start_pos) acc_d = pre_q;
    else if (in_span)          acc_d = acc_q + ACC_W'(step);
    texv_d    = in_span ? texv_sat(acc_d) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pend_full_q <= 1'b0;
      pend_side_q <= 1'b0;
      pend_size_q <= '0;
      pend_texu_q <= '0;
      side_q      <= 1'b0;
      size_q      <= '0;
      texu_q      <= '0;
      texv_q      <= '0;
      busy_q      <= 1'b0;
      underrun_q  <= 1'b0;
      acc_q       <= '0;
      pre_q       <= '0;
      mplier_q    <= '0;
      mcnt_q      <= '0;
    end else begin
      pend_full_q <= pend_full_d;
      underrun_q  <= bus.line_start && !pend_full_q;
      texv_q      <= '0;
      if (accept) begin
        pend_side_q <= bus.in_side;
        pend_size_q <= bus.in_size;
        pend_texu_q <= bus.in_texu;
      end
      if (promote) begin
        side_q <= pend_side_q;
        size_q <= pend_size_q;
        texu_q <= pend_texu_q;
      end

      case (state_q)
        ST_IDLE: ;
        ST_DIV: begin
          if (div_done) begin
            state_q  <= ST_MUL;
            pre_q    <= '0;
            mplier_q <= clip ? (size_q - HALF_S) : '0;
            mcnt_q   <= clip ? MUL_ITERS : 4'd1;
          end
        end
        // MSB-first shift-add of (size-HALF)*step; unclipped lines just pass zero.
        ST_MUL: begin
          pre_q    <= {pre_q[ACC_W-2:0], 1'b0} + (mplier_q[SIZE_W-1] ? ACC_W'(step) : '0);
          mplier_q <= {mplier_q[SIZE_W-2:0], 1'b0};
          mcnt_q   <= mcnt_q - 4'd1;
          if (mcnt_q == 4'd1) begin
            state_q <= ST_READY;
            busy_q  <= 1'b0;
          end
        end
        ST_READY: begin
          acc_q  <= acc_d;
          texv_q <= texv_d;
        end
        default: state_q <= ST_IDLE;
      endcase

      if (bus.line_start) begin
        state_q <= ST_DIV;
        busy_q  <= 1'b1;
      end
    end
  end

  assign bus.in_ready = !pend_full_q;
  assign bus.side     = side_q;
  assign bus.size     = size_q;
  assign bus.texu     = texu_q;
  assign bus.texv     = texv_q;
  assign bus.busy     = busy_q;
  assign bus.underrun = underrun_q;

endmodule
